// File: rtl/dip_scan_deserializer.sv
// Serial-to-parallel scanner for the DIP/switch shift-register chain.
// Generates the load strobe, captures one frame and debounces across frames.
module dip_scan_deserializer #(
  parameter int DIP_W         = 16,
  parameter int SW_W          = 5,
  parameter int PAD_W         = 3,
  parameter int STABLE_FRAMES = 2,
  parameter int BYTE_SWAP     = 1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_Enable,
  input  logic             i_Data,
  output logic             o_DIPLatch,
  output logic [DIP_W-1:0] o_DIP,
  output logic [SW_W-1:0]  o_Switch,
  output logic             o_Valid,
  output logic             o_Changed,
  output logic [2:0]       dbg_state
);

  localparam int N       = DIP_W + SW_W;
  localparam int CNT_MAX = N + PAD_W - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(STABLE_FRAMES + 1);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_PAD   = CNT_W'((PAD_W > 0) ? PAD_W - 1 : 0);
  localparam logic [STB_W-1:0] STB_MAX    = STB_W'(STABLE_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_PAD    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [STB_W-1:0]  stable, stable_next;
  logic [DIP_W-1:0]  cap_dip, prev_dip;
  logic [SW_W-1:0]   cap_sw, prev_sw;
  logic              same_cap;
  logic              do_update;

  always_ff @(posedge i_CLK) begin
    if (i_RESET) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (i_Enable) state_next = S_LOAD;
      S_LOAD:   state_next = S_SHIFT;
      S_SHIFT:  if (cnt == LAST_SHIFT) state_next = (PAD_W > 0) ? S_PAD : S_COMMIT;
      S_PAD:    if (cnt == LAST_PAD) state_next = S_COMMIT;
      S_COMMIT: state_next = i_Enable ? S_LOAD : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign o_DIPLatch = (state != S_LOAD);
  assign dbg_state  = state;

  // stable counts consecutive identical frames, saturating at STABLE_FRAMES
  always_comb begin
    same_cap    = ({cap_dip, cap_sw} == {prev_dip, prev_sw});
    stable_next = STB_W'(1);
    if (same_cap) stable_next = (stable == STB_MAX) ? stable : stable + STB_W'(1);
    do_update = (stable_next == STB_MAX) &&
                (({cap_dip, cap_sw} != {o_DIP, o_Switch}) || !o_Valid);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      cnt       <= '0;
      stable    <= '0;
      cap_dip   <= '0;
      cap_sw    <= '0;
      prev_dip  <= '0;
      prev_sw   <= '0;
      o_DIP     <= '0;
      o_Switch  <= '0;
      o_Valid   <= 1'b0;
      o_Changed <= 1'b0;
    end else begin
      o_Changed <= 1'b0;
      case (state)
        S_SHIFT: begin
          cnt <= (cnt == LAST_SHIFT) ? '0 : cnt + CNT_W'(1);
          // chain bit k lands at k^8 when byte-swapped; the map is its own inverse
          for (int i = 0; i < DIP_W; i++) begin
            if (cnt == CNT_W'((BYTE_SWAP != 0) ? (i ^ 8) : i)) cap_dip[i] <= i_Data;
          end
          for (int j = 0; j < SW_W; j++) begin
            if (cnt == CNT_W'(DIP_W + j)) cap_sw[j] <= i_Data;
          end
        end
        S_PAD: cnt <= cnt + CNT_W'(1);
        S_COMMIT: begin
          cnt      <= '0;
          stable   <= stable_next;
          prev_dip <= cap_dip;
          prev_sw  <= cap_sw;
          if (do_update) begin
            o_DIP     <= cap_dip;
            o_Switch  <= cap_sw;
            o_Valid   <= 1'b1;
            o_Changed <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dip_scan_deserializer.sv
// Directed bench for dip_scan_deserializer: a byte-swapped instance is fully
// checked, a second non-swapped instance sees the same chain stream.
module tb_dip_scan_deserializer;

  localparam int DIP_W = 16;
  localparam int SW_W  = 5;
  localparam int PAD_W = 3;
  localparam int N     = DIP_W + SW_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;

  logic             i_CLK = 1'b0;
  logic             i_RESET, i_Enable, i_Data;
  logic             latch0, latch1;
  logic [DIP_W-1:0] dip0, dip1;
  logic [SW_W-1:0]  sw0, sw1;
  logic             valid0, valid1, chg0, chg1;
  logic [2:0]       st0, st1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int latch_cnt = 0;
  int last_low = 0;
  int prev_low = 0;
  int chg_cnt  = 0;
  int latch_snap;

  always #5 i_CLK = ~i_CLK;

  dip_scan_deserializer #(.BYTE_SWAP(1)) dut (
    .i_CLK(i_CLK), .i_RESET(i_RESET), .i_Enable(i_Enable), .i_Data(i_Data),
    .o_DIPLatch(latch0), .o_DIP(dip0), .o_Switch(sw0), .o_Valid(valid0),
    .o_Changed(chg0), .dbg_state(st0)
  );

  dip_scan_deserializer #(.BYTE_SWAP(0)) dut_noswap (
    .i_CLK(i_CLK), .i_RESET(i_RESET), .i_Enable(i_Enable), .i_Data(i_Data),
    .o_DIPLatch(latch1), .o_DIP(dip1), .o_Switch(sw1), .o_Valid(valid1),
    .o_Changed(chg1), .dbg_state(st1)
  );

  always @(negedge i_CLK) begin
    cyc = cyc + 1;
    if (!latch0) begin
      latch_cnt = latch_cnt + 1;
      prev_low  = last_low;
      last_low  = cyc;
    end
    if (chg0) chg_cnt = chg_cnt + 1;
  end

  task automatic step();
    @(negedge i_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    while (st0 !== ST_LOAD && n < 60) begin
      step();
      n++;
    end
    if (st0 !== ST_LOAD) check("wait_load_timeout", 32'(st0), 32'(ST_LOAD));
  endtask

  // Drives one frame in chain order; ends on the COMMIT cycle.
  task automatic send_frame(input logic [DIP_W-1:0] dip_stream,
                            input logic [SW_W-1:0] sw_stream, input int drop_at);
    logic [N-1:0] bits;
    bits = {sw_stream, dip_stream};
    wait_load();
    for (int k = 0; k < N; k++) begin
      step();
      i_Data = bits[k];
      if (k == drop_at) i_Enable = 1'b0;
    end
    repeat (PAD_W + 1) step();
  endtask

  initial begin
    i_RESET = 1'b1; i_Enable = 1'b0; i_Data = 1'b0;
    repeat (3) step();
    check("rst_state", 32'(st0), 32'(ST_IDLE));
    check("rst_latch", 32'(latch0), 32'd1);
    check("rst_dip", 32'(dip0), 32'd0);
    check("rst_sw", 32'(sw0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_changed", 32'(chg0), 32'd0);

    i_RESET = 1'b0;
    step();
    check("idle_no_enable", 32'(st0), 32'(ST_IDLE));
    check("idle_no_latch", 32'(latch_cnt), 32'd0);

    // Two identical frames: stream k8..15=1, switches 1,0,1,0,1
    i_Enable = 1'b1;
    send_frame(16'hFF00, 5'b10101, -1);
    step();
    check("f1_state_load", 32'(st0), 32'(ST_LOAD));
    check("f1_valid", 32'(valid0), 32'd0);
    check("f1_dip", 32'(dip0), 32'd0);
    check("f1_no_change", 32'(chg_cnt), 32'd0);
    send_frame(16'hFF00, 5'b10101, -1);
    step();
    check("f2_dip", 32'(dip0), 32'h00FF);
    check("f2_sw", 32'(sw0), 32'h15);
    check("f2_valid", 32'(valid0), 32'd1);
    check("f2_changed_now", 32'(chg0), 32'd1);
    check("f2_dip_noswap", 32'(dip1), 32'hFF00);
    check("f2_sw_noswap", 32'(sw1), 32'h15);
    check("frame_period", 32'(last_low - prev_low), 32'd26);

    // One glitched frame (k8 flipped) then the original value again
    send_frame(16'hFE00, 5'b10101, -1);
    send_frame(16'hFF00, 5'b10101, -1);
    step();
    check("glitch_dip", 32'(dip0), 32'h00FF);
    check("glitch_pulses", 32'(chg_cnt), 32'd1);

    // 16'h1234 output needs byte-swapped stream 16'h3412
    send_frame(16'h3412, 5'b00011, -1);
    send_frame(16'h3412, 5'b00011, -1);
    step();
    check("v1234_dip", 32'(dip0), 32'h1234);
    check("v1234_sw", 32'(sw0), 32'h03);
    check("v1234_pulse", 32'(chg0), 32'd1);
    check("v1234_pulses", 32'(chg_cnt), 32'd2);
    check("v1234_noswap", 32'(dip1), 32'h3412);
    send_frame(16'h3412, 5'b00011, -1);
    step();
    check("v1234_third_no_pulse", 32'(chg_cnt), 32'd2);
    check("v1234_third_dip", 32'(dip0), 32'h1234);

    // Reset during SHIFT k=10
    wait_load();
    for (int k = 0; k < 10; k++) begin
      step();
      i_Data = k[0];
    end
    step();
    i_RESET = 1'b1;
    step();
    check("midrst_state", 32'(st0), 32'(ST_IDLE));
    check("midrst_latch", 32'(latch0), 32'd1);
    check("midrst_dip", 32'(dip0), 32'd0);
    check("midrst_sw", 32'(sw0), 32'd0);
    check("midrst_valid", 32'(valid0), 32'd0);
    check("midrst_changed", 32'(chg0), 32'd0);
    i_RESET = 1'b0;
    send_frame(16'hFF00, 5'b10101, -1);
    step();
    check("postrst_f1_valid", 32'(valid0), 32'd0);
    send_frame(16'hFF00, 5'b10101, -1);
    step();
    check("postrst_f2_valid", 32'(valid0), 32'd1);
    check("postrst_f2_dip", 32'(dip0), 32'h00FF);
    check("postrst_pulses", 32'(chg_cnt), 32'd3);

    // Drop enable at SHIFT k=3: frame still commits, then idle
    send_frame(16'h3412, 5'b00011, -1);
    send_frame(16'h3412, 5'b00011, 3);
    step();
    check("drop_state_idle", 32'(st0), 32'(ST_IDLE));
    check("drop_commit_dip", 32'(dip0), 32'h1234);
    check("drop_commit_pulse", 32'(chg0), 32'd1);
    latch_snap = latch_cnt;
    repeat (40) step();
    check("drop_no_latch", 32'(latch_cnt), 32'(latch_snap));
    check("drop_still_idle", 32'(st0), 32'(ST_IDLE));
    i_Enable = 1'b1;
    step();
    check("reenable_load", 32'(st0), 32'(ST_LOAD));
    check("reenable_latch_low", 32'(latch0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dip_scan_deserializer.md
Name: dip_scan_deserializer

Overview:
- Parametrised serial-to-parallel scanner for the board DIP/switch shift-register chain. Successor to the fixed 16+5-bit parallelizer.
- Generates the chain load strobe and deserialises one frame of DIP_W DIP bits plus SW_W switch bits.
- Debounces across consecutive frames before updating the parallel outputs.
- Fully single-edge (posedge i_CLK); feeds the CPU's I/O register bank.

Parameters:
DIP_W, 16, DIP field width (multiple of 16 when BYTE_SWAP=1)
SW_W, 5, switch field width (>=1)
PAD_W, 3, ignored trailing chain bits per frame (>=0)
STABLE_FRAMES, 2, identical consecutive frames required before outputs update (>=1)
BYTE_SWAP, 1, 1: DIP bit k stored at index k^8; 0: stored at index k

Ports:
i_CLK  in  1  clock, all logic on posedge
i_RESET  in  1  synchronous, active-high reset
i_Enable  in  1  1: scan continuously; 0: finish current frame then idle
i_Data  in  1  serial data from chain, sampled on posedge in SHIFT
o_DIPLatch  out  1  active-low chain parallel-load strobe
o_DIP  out  DIP_W  debounced DIP value
o_Switch  out  SW_W  debounced switch value
o_Valid  out  1  high once the first debounced frame is committed
o_Changed  out  1  one-cycle pulse on each output update

Behaviour:
- Reset/clock: i_RESET synchronous, active-high; clock i_CLK. Reset forces:
  - state IDLE, o_DIPLatch=1, o_DIP=0, o_Switch=0, o_Valid=0, o_Changed=0
  - capture, previous-capture, bit counter and stable counter = 0
- Reset has priority over every other event and aborts a frame in progress; the partial frame is discarded.
- Let N = DIP_W+SW_W. FSM states:
  - IDLE: o_DIPLatch=1. If i_Enable=1, go to LOAD.
  - LOAD: one cycle, o_DIPLatch=0, counter cleared. Go to SHIFT.
  - SHIFT: N cycles with count k=0..N-1. Sample i_Data:
    - k<DIP_W: store to capDIP[map(k)].
    - k>=DIP_W: store to capSW[k-DIP_W].
    - At k=N-1, go to PAD if PAD_W>0, else COMMIT.
  - PAD: PAD_W cycles, i_Data ignored. Then COMMIT.
  - COMMIT: one cycle:
    - Debounce: if capture==previous capture, stable=min(stable+1,STABLE_FRAMES); else stable=1. Then previous capture <= capture.
    - Update: if stable (post-update) ==STABLE_FRAMES and (capture!=outputs or o_Valid==0), load outputs from capture on the next edge, set o_Valid=1, pulse o_Changed for exactly one cycle.
    - Exit: if i_Enable=1, go to LOAD; else IDLE.
- Frame period is 1+N+PAD_W+1 cycles (26 at defaults). o_DIPLatch is low exactly once per frame.
- STABLE_FRAMES=1: every frame whose capture differs from outputs (or the first frame) updates.
- Outputs change only in the cycle after COMMIT; they never show partial frames.
- i_Enable dropping mid-frame has no effect until COMMIT. Raising it in IDLE starts LOAD on the next cycle.
- Counters are sized to hold N+PAD_W-1 and STABLE_FRAMES without overflow. The stable counter saturates.

Test Plan:
- Reset then i_Enable=1: o_DIPLatch is low for 1 cycle every 26 cycles; outputs are 0 and o_Valid=0 until the 2nd identical frame.
- Stream DIP bits k0..7=0, k8..15=1, switch bits 1,0,1,0,1 for 2 frames -> o_DIP=16'h00FF, o_Switch=5'h15, o_Valid=1, o_Changed a single pulse. With BYTE_SWAP=0 the same stream gives o_DIP=16'hFF00.
- After a stable 16'h00FF, send one frame with DIP bit k8 flipped, then revert -> outputs unchanged, no o_Changed pulse (glitch rejected).
- Send 3 identical frames of a new value 16'h1234 -> exactly one o_Changed pulse, at the end of the 2nd frame. The 3rd frame causes no pulse.
- Assert i_RESET at SHIFT k=10 -> next cycle all outputs 0, o_DIPLatch=1, state IDLE. A fresh frame then needs 2 stable frames again.
- Drop i_Enable at SHIFT k=3 -> the frame completes and commits, then the block stays in IDLE with no further o_DIPLatch pulses. Re-enable -> LOAD on the next cycle.
